// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generator for a 6-stage pipeline.
// Shadows the EX1/EX2 destination info and registers the selects into the ID/EX boundary.
module fwd_hazard_unit #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             branch_taken,
  input  logic             pipe_hold,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_id,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_count
);

  logic             ex1_valid_q, ex1_rw_q, ex1_ld_q;
  logic [REG_W-1:0] ex1_rd_q;
  // The EX2 load flag never affects a select, so only valid/rd/reg_write are kept there.
  logic             ex2_valid_q, ex2_rw_q;
  logic [REG_W-1:0] ex2_rd_q;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match_a, match_b;
  logic hit1_a, hit1_b, hit2_a, hit2_b;
  logic [1:0] sel_a, sel_b;
  logic kill;

  assign match_a = id_valid & id_use_rs1 & (id_rs1 != '0);
  assign match_b = id_valid & id_use_rs2 & (id_rs2 != '0);
  assign hit1_a  = ex1_valid_q & ex1_rw_q & (ex1_rd_q == id_rs1);
  assign hit1_b  = ex1_valid_q & ex1_rw_q & (ex1_rd_q == id_rs2);
  assign hit2_a  = ex2_valid_q & ex2_rw_q & (ex2_rd_q == id_rs1);
  assign hit2_b  = ex2_valid_q & ex2_rw_q & (ex2_rd_q == id_rs2);

  // Nearest producer wins; a load in EX1 cannot feed from EX2 and is handled by the stall.
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (match_a && hit1_a && !ex1_ld_q) sel_a = 2'b10;
    else if (match_a && hit2_a)         sel_a = 2'b01;
    if (match_b && hit1_b && !ex1_ld_q) sel_b = 2'b10;
    else if (match_b && hit2_b)         sel_b = 2'b01;
  end

  assign flush_id = branch_taken;
  assign stall_id = !branch_taken & ex1_ld_q & ((match_a & hit1_a) | (match_b & hit1_b));
  assign kill     = flush_id | stall_id;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_id && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex1_valid_q <= 1'b0;
      ex1_rw_q    <= 1'b0;
      ex1_ld_q    <= 1'b0;
      ex1_rd_q    <= '0;
      ex2_valid_q <= 1'b0;
      ex2_rw_q    <= 1'b0;
      ex2_rd_q    <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      cnt_q       <= '0;
    end else if (!pipe_hold) begin
      ex2_valid_q <= ex1_valid_q;
      ex2_rw_q    <= ex1_rw_q;
      ex2_rd_q    <= ex1_rd_q;
      cnt_q       <= cnt_d;
      if (kill) begin
        ex1_valid_q <= 1'b0;
        ex1_rw_q    <= 1'b0;
        ex1_ld_q    <= 1'b0;
        ex1_rd_q    <= '0;
        fwd_a_q     <= 2'b00;
        fwd_b_q     <= 2'b00;
      end else begin
        ex1_valid_q <= id_valid;
        ex1_rw_q    <= id_reg_write;
        ex1_ld_q    <= id_is_load;
        ex1_rd_q    <= id_rd;
        fwd_a_q     <= sel_a;
        fwd_b_q     <= sel_b;
      end
    end
  end

  assign forward_a   = fwd_a_q;
  assign forward_b   = fwd_b_q;
  assign stall_count = cnt_q;

endmodule
